// File: rtl/life_pkg.sv
// Shared constants, FSM state type and toroidal neighbour indexing for life_engine.
package life_pkg;

  localparam int unsigned GRID_ROWS = 8;
  localparam int unsigned GRID_COLS = 4;
  localparam int unsigned CELLS     = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StCommit
  } state_t;

  // Cell index is {col[1:0], row[2:0]}; fixed-width adds wrap mod 4 and mod 8 for free.
  function automatic logic [4:0] nbr_index(input logic [4:0] idx, input logic [2:0] drow,
                                           input logic [1:0] dcol);
    logic [2:0] row;
    logic [1:0] col;
    row = idx[2:0] + drow;
    col = idx[4:3] + dcol;
    return {col, row};
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Combinational B3/S23 evaluation of a single cell on the 8x4 torus.
module life_cell_rule
  import life_pkg::*;
(
  input  logic [31:0] grid,
  input  logic [4:0]  index,
  output logic        next_bit,
  output logic [3:0]  count
);

  // Sum the eight wrapped neighbours, then apply birth-on-3 / survive-on-2-or-3.
  always_comb begin
    count = '0;
    for (int dc = -1; dc <= 1; dc++) begin
      for (int dr = -1; dr <= 1; dr++) begin
        if (dr != 0 || dc != 0) begin
          count = count + {3'b000, grid[nbr_index(index, 3'(dr), 2'(dc))]};
        end
      end
    end
    next_bit = (count == 4'd3) || (grid[index] && (count == 4'd2));
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine for the 8x4 LED matrix: one cell evaluated per clock into a back
// buffer, committed to the front buffer every STEP_TICKS clocks.
// Optional build macro: LIFE_AUTO_RESEED_EN reloads from seed after a stable/extinct commit.
module life_engine
  import life_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 6_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        seed_load,
  input  logic        run,
  output logic [31:0] data,
  output logic        busy,
  output logic [15:0] gen_count,
  output logic        stable,
  output logic        extinct
);

  localparam int unsigned TimerW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(STEP_TICKS - 1);

  state_t            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [4:0]        idx_q, idx_d;
  logic [31:0]       front_q, front_d;
  logic [31:0]       back_q, back_d;
  logic [15:0]       gen_q, gen_d;
  logic              stable_q, stable_d;
  logic              extinct_q, extinct_d;
  logic              load;
  logic              timer_wrap;
  logic              rule_bit;
  // Neighbour count is only of interest when probing the rule block.
  logic [3:0]        unused_rule_count;

`ifdef LIFE_AUTO_RESEED_EN
  logic reseed_q, reseed_d;
  assign load = seed_load | reseed_q;
`else
  assign load = seed_load;
`endif

  assign timer_wrap = (timer_q == TimerLast);

  life_cell_rule u_rule (
    .grid     (front_q),
    .index    (idx_q),
    .next_bit (rule_bit),
    .count    (unused_rule_count)
  );

  // Next-state: a load (external or internal) overrides the timer and the step FSM.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_wrap ? '0 : timer_q + 1'b1;
    idx_d     = idx_q;
    front_d   = front_q;
    back_d    = back_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
`ifdef LIFE_AUTO_RESEED_EN
    reseed_d  = 1'b0;
`endif
    if (load) begin
      state_d   = StIdle;
      timer_d   = '0;
      idx_d     = '0;
      front_d   = seed;
      back_d    = '0;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = (seed == 32'd0);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (timer_wrap && run) begin
            state_d = StEval;
            idx_d   = '0;
          end
        end
        StEval: begin
          back_d[idx_q] = rule_bit;
          idx_d         = idx_q + 5'd1;
          if (idx_q == 5'(CELLS - 1)) begin
            state_d = StCommit;
          end
        end
        StCommit: begin
          front_d   = back_q;
          stable_d  = (back_q == front_q);
          extinct_d = (back_q == 32'd0);
          gen_d     = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
          state_d   = StIdle;
`ifdef LIFE_AUTO_RESEED_EN
          reseed_d  = (back_q == front_q) || (back_q == 32'd0);
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; reset aborts any step in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      idx_q     <= '0;
      front_q   <= '0;
      back_q    <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b1;
`ifdef LIFE_AUTO_RESEED_EN
      reseed_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      front_q   <= front_d;
      back_q    <= back_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
`ifdef LIFE_AUTO_RESEED_EN
      reseed_q  <= reseed_d;
`endif
    end
  end

  assign data      = front_q;
  assign busy      = (state_q != StIdle);
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine with a short step period and a cell-by-cell
// Game of Life reference model.
module tb_life_engine;

  localparam int unsigned Ticks = 40;

  logic        clk;
  logic        rst_n;
  logic [31:0] seed;
  logic        seed_load;
  logic        run;
  logic [31:0] data;
  logic        busy;
  logic [15:0] gen_count;
  logic        stable;
  logic        extinct;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_front;
  logic [15:0] m_gen;
  logic        m_stable;
  logic        m_extinct;

  life_engine #(.STEP_TICKS(Ticks)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed      (seed),
    .seed_load (seed_load),
    .run       (run),
    .data      (data),
    .busy      (busy),
    .gen_count (gen_count),
    .stable    (stable),
    .extinct   (extinct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference generation: plain row/col arithmetic with modular wrap.
  function automatic logic [31:0] life_step(input logic [31:0] g);
    logic [31:0] res;
    int n;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) begin
        n = 0;
        for (int dc = -1; dc <= 1; dc++) begin
          for (int dr = -1; dr <= 1; dr++) begin
            if (dc != 0 || dr != 0) begin
              n += int'(g[((c + dc + 4) % 4) * 8 + ((r + dr + 8) % 8)]);
            end
          end
        end
        res[c * 8 + r] = (n == 3) || (g[c * 8 + r] && n == 2);
      end
    end
    return res;
  endfunction

  task automatic model_load(input logic [31:0] s);
    m_front   = s;
    m_gen     = 16'd0;
    m_stable  = 1'b0;
    m_extinct = (s == 32'd0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"}, data, m_front);
    check({tag, "_gen"}, {16'd0, gen_count}, {16'd0, m_gen});
    check({tag, "_stable"}, {31'd0, stable}, {31'd0, m_stable});
    check({tag, "_extinct"}, {31'd0, extinct}, {31'd0, m_extinct});
  endtask

  task automatic do_load(input logic [31:0] s);
    @(negedge clk);
    seed      = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    model_load(s);
    check("load_data", data, s);
    check("load_busy", {31'd0, busy}, 32'd0);
  endtask

  // Wait for one step, check it holds data for 33 busy cycles, then compare results.
  task automatic do_step(input string tag, output int wait_cycles);
    logic [31:0] nxt;
    int hi;
    bit held;
    wait_cycles = 0;
    while (!busy && wait_cycles < 200) begin
      @(negedge clk);
      wait_cycles++;
    end
    check({tag, "_started"}, {31'd0, busy}, 32'd1);
    hi   = 0;
    held = 1'b1;
    while (busy && hi < 60) begin
      if (data !== m_front) held = 1'b0;
      @(negedge clk);
      hi++;
    end
    check({tag, "_busy_len"}, hi, 33);
    check({tag, "_data_held"}, {31'd0, held}, 32'd1);
    nxt       = life_step(m_front);
    m_stable  = (nxt == m_front);
    m_extinct = (nxt == 32'd0);
    m_front   = nxt;
    if (m_gen != 16'hFFFF) m_gen = m_gen + 16'd1;
    check_outputs(tag);
`ifdef LIFE_AUTO_RESEED_EN
    if (m_stable || m_extinct) begin
      @(negedge clk);
      model_load(seed);
      check_outputs({tag, "_reseed"});
    end
`endif
  endtask

  initial begin
    int w;
    int seen;
    logic [15:0] g_hold;
    rst_n     = 1'b0;
    seed      = '0;
    seed_load = 1'b0;
    run       = 1'b1;
    model_load(32'd0);
    m_extinct = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Blinker oscillates; first step starts exactly Ticks edges after the load edge.
    do_load(32'h0000_1C00);
    do_step("blink1", w);
    check("blink1_latency", w, Ticks);
    check("blink1_value", data, 32'h0008_0808);
    do_step("blink2", w);
    check("blink2_value", data, 32'h0000_1C00);

    // Block still-life across the row-7 / col-3 wrap.
    do_load(32'h0000_0303);
    do_step("block", w);

    // Extinction cases.
    do_load(32'hFFFF_FFFF);
    do_step("full", w);
    do_load(32'h0000_0001);
    do_step("single", w);
`ifndef LIFE_AUTO_RESEED_EN
    do_step("empty_keeps_counting", w);
`endif

    // run=0: no steps, gen_count frozen.
    do_load(32'h0000_1C00);
    run    = 1'b0;
    seen   = 0;
    g_hold = gen_count;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("norun_busy", seen, 0);
    check("norun_gen", {16'd0, gen_count}, {16'd0, g_hold});
    check("norun_data", data, m_front);
    run = 1'b1;

    // Abort: seed_load sampled at E10 of a blinker step.
    w = 0;
    while (!busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("abort_started", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    seed      = 32'h0000_0303;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    model_load(32'h0000_0303);
    check_outputs("abort");
    check("abort_busy", {31'd0, busy}, 32'd0);
    do_step("after_abort", w);

    // Asynchronous reset in the middle of a step.
    do_load(32'h0000_1C00);
    w = 0;
    while (!busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_load(32'd0);
    check_outputs("async_rst");
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LIFE_AUTO_RESEED_EN
    // Extinct commit is visible one cycle, then the held seed is loaded.
    do_load(32'h0000_0001);
    seed = 32'h0000_1C00;
    do_step("autoreseed", w);
    check("autoreseed_final", data, 32'h0000_1C00);
`endif

    // Random boards checked against the model over several generations.
    for (int t = 0; t < 6; t++) begin
      do_load($urandom);
      for (int s = 0; s < 3; s++) begin
        do_step("random", w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_engine.md
# life_engine

Conway's Game of Life engine for the 8×4 LED matrix, placed directly upstream of `led_matrix`.
- Holds the current 32-cell generation and drives it on `data`.
- Advances one generation every `STEP_TICKS` clocks by evaluating one cell per clock into a back buffer, then committing the result.
- Seeded from a 32-bit word, typically the sampled `rand_gen` output.

## Interface
- `STEP_TICKS`, default 6_000_000: clocks between generation steps; must be ≥ 40.
- `clk` in 1: system clock (12 MHz).
- `rst_n` in 1: asynchronous active-low reset.
- `seed` in 32: initial generation; loaded when `seed_load` is high.
- `seed_load` in 1: single-cycle load strobe.
- `run` in 1: level; when low, timer ticks are ignored (no steps start).
- `data` out 32: current generation (front buffer); feeds `led_matrix.data`.
- `busy` out 1: high while a step is in progress (EVAL or COMMIT).
- `gen_count` out 16: generations since the last load; saturates at 16'hFFFF.
- `stable` out 1: last committed generation equalled its predecessor.
- `extinct` out 1: last committed generation was all zero.

## Operation
- Cell mapping: bit index = col*8 + row, with col 0..3 and row 0..7.
- Neighbourhood: toroidal, so row and col wrap mod 8 and mod 4. Eight neighbours; the cell itself is excluded.
- Rule B3/S23:
  - A live cell with 2 or 3 live neighbours stays live.
  - A dead cell with exactly 3 live neighbours becomes live.
  - Every other cell is dead in the next generation.
- Neighbour count is 4 bits (0..8).
- Step timer: counts 0..`STEP_TICKS`-1 and wraps; it runs regardless of `run`.
- Step request: the timer wraps, `run`=1, and the state is IDLE.
- State machine:
  - IDLE: waits for a step request; then index ← 0 and go to EVAL.
  - EVAL: `back[index]` ← rule(front, index); index++. After index 31 is written, go to COMMIT.
  - COMMIT:
    - front ← back.
    - `stable` ← (back == front).
    - `extinct` ← (back == 0).
    - `gen_count` saturating-increments.
    - Go to IDLE.
- `seed_load` has priority over everything, in any state:
  - front ← `seed`, back ← 0, state ← IDLE.
  - timer ← 0, `gen_count` ← 0, `stable` ← 0.
  - `extinct` ← (`seed` == 0).
  - An in-flight step is discarded. If `seed_load` coincides with a step request, no step starts.
- Reset values:
  - `data`=0, `busy`=0, `gen_count`=0, `stable`=0, `extinct`=1.
  - State IDLE, timer 0, back 0.
- Reset asserted mid-step aborts the step immediately.
- An all-zero or stable board keeps stepping, and `gen_count` keeps counting (unless the feature below is compiled in).

## Timing
- E0 is the clock edge at which the timer wraps with the step request true; the state enters EVAL with index 0.
- Edges E1..E32 write back cells 0..31 (cell k written at E(k+1)); E32 also enters COMMIT.
- E33: `data`, `gen_count`, `stable` and `extinct` update; the state returns to IDLE.
- `busy` is high for the cycles between E0 and E33 (33 cycles).
- `data` changes only at a COMMIT edge or a `seed_load` edge; it is glitch-free for `led_matrix`.
- Seed latency: `data` equals `seed` on the edge that samples `seed_load`=1.

## Configuration
- `LIFE_AUTO_RESEED_EN` defined:
  - At a COMMIT where the next generation is stable or extinct, the following clock performs an internal seed load from the current `seed` input.
  - The internal load has identical effects to `seed_load`.
  - `stable`/`extinct` are visible for that one cycle before clearing.
- `LIFE_AUTO_RESEED_EN` undefined: no automatic load; the flags hold until the next COMMIT or load.

## Structure
- Package `life_pkg`:
  - Constants GRID_ROWS=8, GRID_COLS=4, CELLS=32.
  - State typedef (IDLE, EVAL, COMMIT).
  - Wrap-aware neighbour-index function.
- Sub-module `life_cell_rule`: combinational.
  - Inputs: 32-bit grid and 5-bit index.
  - Outputs: next-state bit and neighbour count.
  - One instance, time-shared across the 32 EVAL cycles.
- Top: timer, FSM, front/back registers, flags.

## Test plan
- Blinker: load 0x00001C00, `run`=1 → after one step `data`=0x00080808; after two, 0x00001C00. `gen_count` 1 then 2; `stable`=0.
- Block: load 0x00000303 → after one step `data`=0x00000303, `stable`=1, `extinct`=0 (checks torus wrap at row 7 and col 3).
- Extinction: load 0xFFFFFFFF → one step gives `data`=0, `extinct`=1. Load 0x00000001 → `data`=0 after one step.
- Timing: with `STEP_TICKS`=40, `busy` rises the cycle after the wrap and stays high 33 cycles. `data` changes exactly at E33. `run`=0 gives no steps and `gen_count` stays constant.
- Abort: pulse `seed_load` with `seed`=0x00000303 at E10 of a blinker step → `data`=0x00000303, `gen_count`=0, `busy`=0 next cycle. Assert `rst_n`=0 mid-step → all outputs take their reset values asynchronously.
- With `LIFE_AUTO_RESEED_EN`: load 0x00000001 with `seed` held at 0x00001C00 → after the step, `extinct`=1 for one cycle, then `data`=0x00001C00 and `gen_count`=0.
